// File: rtl/if_pkg.sv
// if_pkg: shared definitions for the instruction-fetch controller.
//   - if_state_e : fetch FSM encodings (IDLE/REQ/HOLD/KILL)
//   - PC_STEP    : byte distance between sequential instructions
//   - NOP_INST   : filler word pushed with a misaligned-fetch exception
//   - SKID_*     : depth and counter width of the decode-side skid buffer
package if_pkg;

    localparam int unsigned PC_STEP    = 4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned SKID_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } if_state_e;

endpackage : if_pkg

// File: rtl/if_fetch_skid.sv
// if_skid: 2-entry FIFO between fetch and decode.
// Entry 0 is always the head, so the outputs come straight from a register.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push_i/inst_i/pc_i/exc_i   write one entry
//   pop_i               remove the head (ignored when empty)
//   flush_i             drop all entries; wins over push and pop
//   inst_o/pc_o/exc_o   head entry
//   valid_o             buffer non-empty
//   count_o             number of entries held (0..2)
module if_skid
    import if_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [INST_W-1:0]     inst_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic                  exc_i,
    output logic [INST_W-1:0]     inst_o,
    output logic [XLEN-1:0]       pc_o,
    output logic                  exc_o,
    output logic                  valid_o,
    output logic [SKID_CNT_W-1:0] count_o
);

    localparam int unsigned EW = INST_W + XLEN + 1;

    logic [EW-1:0]         e0_q, e0_d;
    logic [EW-1:0]         e1_q, e1_d;
    logic [EW-1:0]         din;
    logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
    logic                  do_push;
    logic                  do_pop;

    // Next-state for the two entries and the occupancy count.
    always_comb begin
        din     = {inst_i, pc_i, exc_i};
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        do_pop  = pop_i && (cnt_q != '0);
        // A push into a full buffer is only legal when a pop frees a slot.
        do_push = push_i && ((cnt_q < SKID_CNT_W'(SKID_DEPTH)) || do_pop);
        if (flush_i) begin
            cnt_d = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == '0) e0_d = din;
                    else             e1_d = din;
                    cnt_d = cnt_q + SKID_CNT_W'(1);
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - SKID_CNT_W'(1);
                end
                2'b11: begin
                    if (cnt_q == SKID_CNT_W'(1)) begin
                        e0_d = din;
                    end else begin
                        e0_d = e1_q;
                        e1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign {inst_o, pc_o, exc_o} = e0_q;
    assign valid_o               = (cnt_q != '0);
    assign count_o               = cnt_q;

endmodule : if_skid

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch controller; sole writer of the PC register.
// Issues a held req/ack transaction per instruction and hands fetched words
// to decode through a 2-entry skid buffer.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pc                       current PC from the PC register
//   pcwe, npc                PC write enable / next PC (combinational)
//   redirect, redirect_pc    branch/jump taken pulse and target
//   imem_req, imem_addr      registered memory request and word address
//   imem_ack, imem_rdata     memory acknowledge with same-cycle data
//   if_valid, if_ready       decode handshake
//   if_inst, if_pc, if_exc   head instruction, its PC, misaligned-fetch flag
// Build option: IF_FETCH_ALIGN_CHECK_EN turns a misaligned PC into an
// exception entry instead of a fetch of the aligned word.
module if_fetch
    import if_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc,
    output logic              pcwe,
    output logic [XLEN-1:0]   npc,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [INST_W-1:0] if_inst,
    output logic [XLEN-1:0]   if_pc,
    output logic              if_exc
);

`ifdef IF_FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    if_state_e             state_q, state_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic                  req_q, req_d;
    logic                  lock_q, lock_d;

    logic [XLEN-1:0]       issue_src;
    logic [XLEN-1:0]       issue_addr;
    logic                  issue_bad;
    logic                  go_issue;

    logic                  push;
    logic                  pop;
    logic                  flush;
    logic [INST_W-1:0]     push_inst;
    logic [XLEN-1:0]       push_pc;
    logic                  push_exc;
    logic                  skid_valid;
    logic                  skid_exc;
    logic [INST_W-1:0]     skid_inst;
    logic [XLEN-1:0]       skid_pc;
    logic [SKID_CNT_W-1:0] skid_cnt;
    logic [SKID_CNT_W-1:0] cnt_after_ack;

    assign pop = skid_valid && if_ready;

    // Address a new request would use. A redirect target is taken directly
    // because the PC register only picks it up at the coming edge.
    always_comb begin
        issue_src     = redirect ? redirect_pc : pc;
        issue_addr    = {issue_src[XLEN-1:2], 2'b00};
        issue_bad     = ALIGN_CHECK && (issue_src[1:0] != 2'b00);
        cnt_after_ack = skid_cnt + SKID_CNT_W'(1) - SKID_CNT_W'(pop);
    end

    // Next-state, PC update and skid control.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lock_d    = lock_q;
        pcwe      = 1'b0;
        npc       = '0;
        push      = 1'b0;
        push_inst = imem_rdata;
        push_pc   = addr_q;
        push_exc  = 1'b0;
        flush     = 1'b0;
        go_issue  = 1'b0;

        if (redirect) begin
            pcwe   = 1'b1;
            npc    = redirect_pc;
            flush  = 1'b1;
            lock_d = 1'b0;
            case (state_q)
                REQ:     if (imem_ack) go_issue = 1'b1;
                         else          state_d  = KILL;
                // Old transaction still outstanding: wait for its ack.
                KILL:    if (imem_ack) go_issue = 1'b1;
                default: go_issue = 1'b1;
            endcase
        end else begin
            case (state_q)
                IDLE: go_issue = 1'b1;
                REQ: begin
                    if (imem_ack) begin
                        push    = 1'b1;
                        pcwe    = 1'b1;
                        npc     = addr_q + XLEN'(PC_STEP);
                        // IDLE gives the PC register one edge to take npc.
                        state_d = (cnt_after_ack == SKID_CNT_W'(SKID_DEPTH)) ? HOLD : IDLE;
                    end
                end
                HOLD: if (!lock_q && (skid_cnt <= SKID_CNT_W'(1))) go_issue = 1'b1;
                KILL: if (imem_ack) go_issue = 1'b1;
                default: state_d = IDLE;
            endcase
        end

        if (go_issue) begin
            if (!issue_bad) begin
                state_d = REQ;
                addr_d  = issue_addr;
            end else if (redirect) begin
                // Misaligned target: report it once the PC register holds it.
                state_d = IDLE;
            end else begin
                push      = 1'b1;
                push_inst = INST_W'(NOP_INST);
                push_pc   = pc;
                push_exc  = ALIGN_CHECK;
                lock_d    = 1'b1;
                state_d   = HOLD;
            end
        end

        req_d = (state_d == REQ) || (state_d == KILL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            req_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            lock_q  <= lock_d;
        end
    end

    if_skid #(
        .XLEN   (XLEN),
        .INST_W (INST_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .inst_i  (push_inst),
        .pc_i    (push_pc),
        .exc_i   (push_exc),
        .inst_o  (skid_inst),
        .pc_o    (skid_pc),
        .exc_o   (skid_exc),
        .valid_o (skid_valid),
        .count_o (skid_cnt)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = skid_valid;
    assign if_inst   = skid_inst;
    assign if_pc     = skid_pc;
    assign if_exc    = skid_exc;

endmodule : if_fetch
